// File: rtl/exe_cmd_issue_if.sv
`default_nettype none
// ============================================================================
//  Module   : exe_cmd_issue_if
//  Purpose  : Bundles the command, exe-unit and result signals of
//             exe_cmd_issue into one interface.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signal groups (names are from the issue stage's point of view)
//    command in  : i_valid, o_ready, i_oper, i_argA, i_argB
//    exe unit    : o_exe_oper, o_exe_argA, o_exe_argB (drive the exe unit),
//                  i_exe_result, i_exe_status (its combinational outputs)
//    result out  : o_valid, i_ready, o_oper, o_result, o_status
//    occupancy   : o_count
//  Modports
//    slave  : the issue stage itself
//    master : the surrounding logic (upstream, exe unit, downstream)
// ============================================================================
interface exe_cmd_issue_if #(
  parameter int M     = 4,
  parameter int N     = 2,
  parameter int DEPTH = 4
);
  logic                     i_valid;
  logic                     o_ready;
  logic [N-1:0]             i_oper;
  logic [M-1:0]             i_argA;
  logic [M-1:0]             i_argB;
  logic [N-1:0]             o_exe_oper;
  logic [M-1:0]             o_exe_argA;
  logic [M-1:0]             o_exe_argB;
  logic [M-1:0]             i_exe_result;
  logic [M-1:0]             i_exe_status;
  logic                     o_valid;
  logic                     i_ready;
  logic [N-1:0]             o_oper;
  logic [M-1:0]             o_result;
  logic [M-1:0]             o_status;
  logic [$clog2(DEPTH):0]   o_count;

  modport slave (
    input  i_valid, i_oper, i_argA, i_argB, i_exe_result, i_exe_status, i_ready,
    output o_ready, o_exe_oper, o_exe_argA, o_exe_argB,
           o_valid, o_oper, o_result, o_status, o_count
  );

  modport master (
    output i_valid, i_oper, i_argA, i_argB, i_exe_result, i_exe_status, i_ready,
    input  o_ready, o_exe_oper, o_exe_argA, o_exe_argB,
           o_valid, o_oper, o_result, o_status, o_count
  );
endinterface
`default_nettype wire

// File: rtl/exe_cmd_issue.sv
`default_nettype none
// ============================================================================
//  Module   : exe_cmd_issue
//  Purpose  : Issue/retire stage around exe_unit_w12. Commands are queued in
//             a DEPTH-entry FIFO, the FIFO head drives the exe unit, and the
//             exe unit's combinational result/status is captured into a
//             registered output slot that drains over valid/ready.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk   in  clock, rising edge
//    i_rsn   in  reset, asynchronous, active-low
//    bus     slave modport of exe_cmd_issue_if:
//              command in  (i_valid/o_ready, i_oper, i_argA, i_argB)
//              exe drive   (o_exe_*), exe return (i_exe_result/i_exe_status)
//              result out  (o_valid/i_ready, o_oper, o_result, o_status)
//              o_count     commands currently queued
// ============================================================================
module exe_cmd_issue #(
  parameter int M     = 4,
  parameter int N     = 2,
  parameter int DEPTH = 4
) (
  input  wire logic          i_clk,
  input  wire logic          i_rsn,
  exe_cmd_issue_if.slave     bus
);

  localparam int              PW         = $clog2(DEPTH);
  localparam int              CW         = PW + 1;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

  // Command storage; contents need no reset because the head is masked to
  // zero whenever the queue is empty.
  logic [N-1:0] oper_mem [DEPTH];
  logic [M-1:0] arga_mem [DEPTH];
  logic [M-1:0] argb_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  // Keeps o_ready low during reset; goes high on the first edge after release.
  logic          accept_en;

  logic          res_valid;
  logic [N-1:0]  res_oper;
  logic [M-1:0]  res_result;
  logic [M-1:0]  res_status;

  logic          not_empty;
  logic          ready_int;
  logic          push;
  logic          issue;

  assign not_empty = (count != '0);
  // Ready depends only on occupancy: no bypass and no look-ahead at the pop.
  assign ready_int = accept_en && (count != FULL_COUNT);
  assign push      = bus.i_valid && ready_int;
  // The slot can take a new result when it is empty or being drained now.
  assign issue     = not_empty && (!res_valid || bus.i_ready);

  // Queue pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      accept_en <= 1'b0;
    end else begin
      accept_en <= 1'b1;
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (issue) rd_ptr <= rd_ptr + PW'(1);
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      oper_mem[wr_ptr] <= bus.i_oper;
      arga_mem[wr_ptr] <= bus.i_argA;
      argb_mem[wr_ptr] <= bus.i_argB;
    end
  end

  // Result slot: load on issue, clear the valid on a drain with nothing
  // behind it, otherwise hold (covers backpressure).
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      res_valid  <= 1'b0;
      res_oper   <= '0;
      res_result <= '0;
      res_status <= '0;
    end else if (issue) begin
      res_valid  <= 1'b1;
      res_oper   <= oper_mem[rd_ptr];
      res_result <= bus.i_exe_result;
      res_status <= bus.i_exe_status;
    end else if (res_valid && bus.i_ready) begin
      res_valid  <= 1'b0;
    end
  end

  // An empty queue presents oper 0 with 0+0 to the exe unit.
  assign bus.o_exe_oper = not_empty ? oper_mem[rd_ptr] : '0;
  assign bus.o_exe_argA = not_empty ? arga_mem[rd_ptr] : '0;
  assign bus.o_exe_argB = not_empty ? argb_mem[rd_ptr] : '0;

  assign bus.o_ready  = ready_int;
  assign bus.o_count  = count;
  assign bus.o_valid  = res_valid;
  assign bus.o_oper   = res_oper;
  assign bus.o_result = res_result;
  assign bus.o_status = res_status;

endmodule
`default_nettype wire

// File: tb/tb_exe_cmd_issue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_exe_cmd_issue
//  Purpose  : Directed self-checking bench for exe_cmd_issue, with a small
//             behavioural stand-in for exe_unit_w12 on the exe-side signals.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exe_cmd_issue;
  localparam int M     = 4;
  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic i_clk = 1'b0;
  logic i_rsn;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 i_clk = ~i_clk;

  exe_cmd_issue_if #(.M(M), .N(N), .DEPTH(DEPTH)) bus ();

  exe_cmd_issue #(.M(M), .N(N), .DEPTH(DEPTH)) dut (
    .i_clk (i_clk),
    .i_rsn (i_rsn),
    .bus   (bus)
  );

  // Exe unit stand-in: 00 add, 01 and, 10 or, 11 one-hot of B (range error
  // when B >= 4). Status = {2'b00, zero, range_error}.
  function automatic logic [7:0] exe_model(input logic [1:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
    logic [3:0] r;
    logic       err;
    r   = '0;
    err = 1'b0;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a & b;
      2'b10:   r = a | b;
      default: begin
        if (b >= 4'd4) err = 1'b1;
        else           r   = 4'b0001 << b;
      end
    endcase
    return {2'b00, (r == 4'd0), err, r};
  endfunction

  assign {bus.i_exe_status, bus.i_exe_result} =
      exe_model(bus.o_exe_oper, bus.o_exe_argA, bus.o_exe_argB);

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.i_valid = 1'b1;
    bus.i_oper  = op;
    bus.i_argA  = a;
    bus.i_argB  = b;
  endtask

  // One command through an idle block with i_ready=1.
  task automatic single(input string tag, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] res, input logic [3:0] st);
    send(op, a, b);
    tick();
    bus.i_valid = 1'b0;
    check({tag, "_count_after_push"}, 8'(bus.o_count), 8'd1);
    check({tag, "_valid_before"},     8'(bus.o_valid), 8'd0);
    tick();
    check({tag, "_valid"},  8'(bus.o_valid),  8'd1);
    check({tag, "_result"}, 8'(bus.o_result), 8'(res));
    check({tag, "_status"}, 8'(bus.o_status), 8'(st));
    check({tag, "_oper"},   8'(bus.o_oper),   8'(op));
    check({tag, "_count"},  8'(bus.o_count),  8'd0);
    tick();
    check({tag, "_drained"}, 8'(bus.o_valid),  8'd0);
    check({tag, "_hold"},    8'(bus.o_result), 8'(res));
  endtask

  initial begin
    // ---- Reset held with a command waiting upstream
    i_rsn       = 1'b0;
    bus.i_ready = 1'b1;
    send(2'b00, 4'd3, 4'd5);
    tick();
    tick();
    check("rst_ready",  8'(bus.o_ready),  8'd0);
    check("rst_valid",  8'(bus.o_valid),  8'd0);
    check("rst_count",  8'(bus.o_count),  8'd0);
    check("rst_result", 8'(bus.o_result), 8'd0);
    check("rst_exe_a",  8'(bus.o_exe_argA), 8'd0);

    bus.i_valid = 1'b0;
    i_rsn       = 1'b1;
    tick();
    check("post_rst_ready", 8'(bus.o_ready), 8'd1);
    check("post_rst_count", 8'(bus.o_count), 8'd0);

    // ---- Single operations
    single("add_3_5",  2'b00, 4'd3, 4'd5, 4'b1000, 4'b0000);
    check("idle_exe_oper", 8'(bus.o_exe_oper), 8'd0);
    check("idle_exe_b",    8'(bus.o_exe_argB), 8'd0);
    single("and_2_5",  2'b01, 4'd2, 4'd5, 4'b0000, 4'b0010);
    single("sel_0_2",  2'b11, 4'd0, 4'd2, 4'b0100, 4'b0000);
    single("sel_0_5",  2'b11, 4'd0, 4'd5, 4'b0000, 4'b0011);

    // ---- Backpressure: commands A=k,B=k (add) give results 2k
    bus.i_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(2'b00, 4'(k), 4'(k));
      tick();
    end
    send(2'b00, 4'd6, 4'd6);
    check("bp_count_full", 8'(bus.o_count),  8'd4);
    check("bp_ready_low",  8'(bus.o_ready),  8'd0);
    check("bp_slot_valid", 8'(bus.o_valid),  8'd1);
    check("bp_slot_res",   8'(bus.o_result), 8'd2);
    tick();
    check("bp_hold_res",   8'(bus.o_result), 8'd2);
    check("bp_hold_count", 8'(bus.o_count),  8'd4);
    bus.i_ready = 1'b1;
    tick();
    check("bp_r2",       8'(bus.o_result), 8'd4);
    check("bp_r2_count", 8'(bus.o_count),  8'd3);
    check("bp_r2_ready", 8'(bus.o_ready),  8'd1);
    tick();
    bus.i_valid = 1'b0;
    check("bp_r3",       8'(bus.o_result), 8'd6);
    check("bp_r3_count", 8'(bus.o_count),  8'd3);
    tick();
    check("bp_r4",       8'(bus.o_result), 8'd8);
    tick();
    check("bp_r5",       8'(bus.o_result), 8'd10);
    tick();
    check("bp_r6",       8'(bus.o_result), 8'd12);
    check("bp_r6_valid", 8'(bus.o_valid),  8'd1);
    check("bp_r6_count", 8'(bus.o_count),  8'd0);
    tick();
    check("bp_drained",  8'(bus.o_valid),  8'd0);

    // ---- Streaming: A=k,B=3 add, results k+3, one per cycle
    for (int k = 0; k < 8; k++) begin
      send(2'b00, 4'(k), 4'd3);
      tick();
      check("st_count", 8'(bus.o_count), 8'd1);
      if (k > 0) begin
        check("st_valid",  8'(bus.o_valid),  8'd1);
        check("st_result", 8'(bus.o_result), 8'(k + 2));
      end
    end
    bus.i_valid = 1'b0;
    tick();
    check("st_last_valid",  8'(bus.o_valid),  8'd1);
    check("st_last_result", 8'(bus.o_result), 8'd10);
    check("st_last_count",  8'(bus.o_count),  8'd0);
    tick();

    // ---- Reset in the middle of a burst (op 11, B=1 -> result 0010)
    bus.i_ready = 1'b0;
    send(2'b11, 4'd0, 4'd1);
    tick();
    tick();
    tick();
    check("mr_pre_count", 8'(bus.o_count), 8'd2);
    check("mr_pre_oper",  8'(bus.o_oper),  8'd3);
    #2;
    i_rsn = 1'b0;
    #1;
    check("mr_valid",  8'(bus.o_valid),  8'd0);
    check("mr_count",  8'(bus.o_count),  8'd0);
    check("mr_ready",  8'(bus.o_ready),  8'd0);
    check("mr_result", 8'(bus.o_result), 8'd0);
    check("mr_status", 8'(bus.o_status), 8'd0);
    check("mr_oper",   8'(bus.o_oper),   8'd0);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    i_rsn = 1'b1;
    tick();
    tick();
    check("mr_lost_valid", 8'(bus.o_valid), 8'd0);
    check("mr_lost_count", 8'(bus.o_count), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
